// File: rtl/axi4_stream_protocol_monitor.sv
// Passive AXI4-Stream protocol monitor: flags handshake/payload/liveness violations
// as registered pulses plus sticky/first-error captures, and counts accepted beats and packets.
module axi4_stream_protocol_monitor #(
  parameter int DATA_WIDTH        = 64,
  parameter int MAX_STALL_CYCLES  = 1024,
  parameter int MAX_PKT_BEATS     = 4096,
  parameter int ALLOW_SPARSE_KEEP = 1,
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     tvalid,
  input  logic                     tready,
  input  logic [DATA_WIDTH-1:0]    tdata,
  input  logic [DATA_WIDTH/8-1:0]  tkeep,
  input  logic [DATA_WIDTH/8-1:0]  tstrb,
  input  logic                     tlast,
  input  logic                     clr,
  output logic [5:0]               err_pulse,
  output logic [5:0]               err_sticky,
  output logic [5:0]               first_err,
  output logic [COUNT_WIDTH-1:0]   beat_count,
  output logic [COUNT_WIDTH-1:0]   pkt_count
);

  localparam int KW  = DATA_WIDTH / 8;
  localparam int PW  = DATA_WIDTH + 2 * KW + 1;
  localparam int SCW = $clog2(MAX_STALL_CYCLES + 1);
  localparam int PBW = $clog2(MAX_PKT_BEATS + 2);

  localparam logic [SCW-1:0] STALL_MAX  = SCW'(MAX_STALL_CYCLES);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(MAX_STALL_CYCLES - 1);
  localparam logic [PBW-1:0] PKT_MAX    = PBW'(MAX_PKT_BEATS);
  localparam logic [PBW-1:0] PKT_SAT    = PBW'(MAX_PKT_BEATS + 1);

  localparam int E_VALID_DROP     = 0;
  localparam int E_PAYLOAD_CHANGE = 1;
  localparam int E_STRB_NOT_KEEP  = 2;
  localparam int E_STALL_TIMEOUT  = 3;
  localparam int E_PKT_TOO_LONG   = 4;
  localparam int E_KEEP_SPARSE    = 5;

  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $fatal(1, "DATA_WIDTH must be a positive multiple of 8");
  end
  if (MAX_STALL_CYCLES < 1 || MAX_PKT_BEATS < 1) begin : g_bad_limits
    $fatal(1, "MAX_STALL_CYCLES and MAX_PKT_BEATS must be >= 1");
  end

  logic           accept;
  logic           stall_now;
  logic           keep_sparse;
  logic [PW-1:0]  payload;

  logic                   stalled_q,    stalled_d;
  logic [PW-1:0]          copy_q,       copy_d;
  logic [SCW-1:0]         stall_cnt_q,  stall_cnt_d;
  logic [PBW-1:0]         pkt_beats_q,  pkt_beats_d;
  logic [5:0]             err_pulse_q,  err_pulse_d;
  logic [5:0]             err_sticky_q, err_sticky_d;
  logic [5:0]             first_err_q,  first_err_d;
  logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [COUNT_WIDTH-1:0] pkt_count_q,  pkt_count_d;

  assign accept    = tvalid & tready;
  assign stall_now = tvalid & ~tready;
  assign payload   = {tdata, tkeep, tstrb, tlast};

  if (ALLOW_SPARSE_KEEP != 0) begin : g_sparse_ok
    assign keep_sparse = 1'b0;
  end else begin : g_sparse_chk
    assign keep_sparse = tvalid & ~tlast & ~(&tkeep);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    err_pulse_d = '0;
    err_pulse_d[E_VALID_DROP]     = stalled_q & ~tvalid;
    err_pulse_d[E_PAYLOAD_CHANGE] = stalled_q & tvalid & (payload != copy_q);
    err_pulse_d[E_STRB_NOT_KEEP]  = tvalid & (|(tstrb & ~tkeep));
    // Counter saturates at the limit, so this equality can only hit once per stall episode.
    err_pulse_d[E_STALL_TIMEOUT]  = stall_now & (stall_cnt_q == STALL_LAST);
    err_pulse_d[E_PKT_TOO_LONG]   = accept & (pkt_beats_q == PKT_MAX);
    err_pulse_d[E_KEEP_SPARSE]    = keep_sparse;

    stalled_d = stall_now;
    copy_d    = stall_now ? payload : copy_q;

    stall_cnt_d = '0;
    if (stall_now) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 1'b1;
    end

    pkt_beats_d = pkt_beats_q;
    if (accept) begin
      if (tlast)                        pkt_beats_d = '0;
      else if (pkt_beats_q != PKT_SAT)  pkt_beats_d = pkt_beats_q + 1'b1;
    end

    // clr wipes the reporting state first; this cycle's events are then applied on top.
    err_sticky_d = (clr ? 6'd0 : err_sticky_q) | err_pulse_d;
    first_err_d  = clr ? 6'd0 : first_err_q;
    if (first_err_d == 6'd0) first_err_d = err_pulse_d;

    beat_count_d = clr ? '0 : beat_count_q;
    if (accept && !(&beat_count_d)) beat_count_d = beat_count_d + 1'b1;
    pkt_count_d  = clr ? '0 : pkt_count_q;
    if (accept && tlast && !(&pkt_count_d)) pkt_count_d = pkt_count_d + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stalled_q    <= 1'b0;
      // NOTE: the payload copy is reset too, so the monitor starts from a fully known state.
      copy_q       <= '0;
      stall_cnt_q  <= '0;
      pkt_beats_q  <= '0;
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
      first_err_q  <= '0;
      beat_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      stalled_q    <= stalled_d;
      copy_q       <= copy_d;
      stall_cnt_q  <= stall_cnt_d;
      pkt_beats_q  <= pkt_beats_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      first_err_q  <= first_err_d;
      beat_count_q <= beat_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign first_err  = first_err_q;
  assign beat_count = beat_count_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_axi4_stream_protocol_monitor.sv
// Self-checking bench for axi4_stream_protocol_monitor: a cycle model pushes expected
// outputs to a scoreboard queue each driven cycle; they are popped and compared after the edge.
module tb_axi4_stream_protocol_monitor;

  localparam int DW        = 16;
  localparam int KW        = DW / 8;
  localparam int PW        = DW + 2 * KW + 1;
  localparam int MAX_STALL = 4;
  localparam int MAX_PKT   = 3;
  localparam int CW        = 4;
  localparam int CNT_SAT   = (1 << CW) - 1;

  logic          aclk, aresetn, tvalid, tready, tlast, clr;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep, tstrb;
  logic [5:0]    err_pulse, err_sticky, first_err;
  logic [CW-1:0] beat_count, pkt_count;

  typedef struct {
    logic [5:0]    err;
    logic [5:0]    sticky;
    logic [5:0]    first;
    logic [CW-1:0] beats;
    logic [CW-1:0] pkts;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_timeout = 0;

  int          m_stall_cnt, m_pkt_beats, m_beats, m_pkts;
  bit          m_stalled;
  logic [PW-1:0] m_copy;
  logic [5:0]  m_sticky, m_first;

  axi4_stream_protocol_monitor #(
    .DATA_WIDTH        (DW),
    .MAX_STALL_CYCLES  (MAX_STALL),
    .MAX_PKT_BEATS     (MAX_PKT),
    .ALLOW_SPARSE_KEEP (0),
    .COUNT_WIDTH       (CW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .tvalid     (tvalid),
    .tready     (tready),
    .tdata      (tdata),
    .tkeep      (tkeep),
    .tstrb      (tstrb),
    .tlast      (tlast),
    .clr        (clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .first_err  (first_err),
    .beat_count (beat_count),
    .pkt_count  (pkt_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stall_cnt = 0;
    m_pkt_beats = 0;
    m_beats     = 0;
    m_pkts      = 0;
    m_stalled   = 1'b0;
    m_copy      = '0;
    m_sticky    = '0;
    m_first     = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"},  32'(err_pulse),  32'd0);
    check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
    check({tag, "_first"},  32'(first_err),  32'd0);
    check({tag, "_beats"},  32'(beat_count), 32'd0);
    check({tag, "_pkts"},   32'(pkt_count),  32'd0);
  endtask

  // Drive one cycle, predict the registered outputs, and compare after the edge.
  task automatic cycle(input bit tv, input bit tr, input logic [DW-1:0] d,
                       input logic [KW-1:0] k, input logic [KW-1:0] s,
                       input bit l, input bit c);
    exp_t          e;
    logic [5:0]    ev;
    logic [PW-1:0] pl;
    tvalid = tv; tready = tr; tdata = d; tkeep = k; tstrb = s; tlast = l; clr = c;
    pl = {d, k, s, l};
    ev = '0;
    if (m_stalled && !tv)                 ev[0] = 1'b1;
    if (m_stalled && tv && pl != m_copy)  ev[1] = 1'b1;
    if (tv && ((s & ~k) != '0))           ev[2] = 1'b1;
    if (tv && !tr) begin
      m_stall_cnt++;
      if (m_stall_cnt == MAX_STALL) ev[3] = 1'b1;
    end else begin
      m_stall_cnt = 0;
    end
    if (tv && tr) begin
      m_pkt_beats++;
      if (m_pkt_beats == MAX_PKT + 1) ev[4] = 1'b1;
      if (l) m_pkt_beats = 0;
    end
    if (tv && !l && k != {KW{1'b1}})      ev[5] = 1'b1;
    if (c) begin
      m_sticky = '0; m_first = '0; m_beats = 0; m_pkts = 0;
    end
    m_sticky |= ev;
    if (m_first == '0) m_first = ev;
    if (tv && tr && m_beats < CNT_SAT)      m_beats++;
    if (tv && tr && l && m_pkts < CNT_SAT)  m_pkts++;
    m_stalled = tv && !tr;
    if (tv && !tr) m_copy = pl;
    e.err = ev; e.sticky = m_sticky; e.first = m_first;
    e.beats = CW'(m_beats); e.pkts = CW'(m_pkts);
    sb.push_back(e);

    @(posedge aclk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("err_pulse",  32'(err_pulse),  32'(e.err));
      check("err_sticky", 32'(err_sticky), 32'(e.sticky));
      check("first_err",  32'(first_err),  32'(e.first));
      check("beat_count", 32'(beat_count), 32'(e.beats));
      check("pkt_count",  32'(pkt_count),  32'(e.pkts));
    end
    if (err_pulse[3]) n_timeout++;
  endtask

  task automatic idle(input bit c);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, c);
  endtask

  initial begin
    aresetn = 1'b0;
    tvalid = 1'b0; tready = 1'b0; tdata = '0; tkeep = '0; tstrb = '0; tlast = 1'b0; clr = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // T1: reset in the middle of a stall, then an idle cycle must not report a drop.
    repeat (5) cycle(1'b1, 1'b0, 16'h00C3, 2'b11, 2'b11, 1'b0, 1'b0);
    aresetn = 1'b0;
    #1;
    check_all_zero("t1_async");
    model_reset();
    #1;
    aresetn = 1'b1;
    idle(1'b0);
    check("t1_no_drop", 32'(err_pulse), 32'd0);

    // T2: stall then tvalid drop.
    cycle(1'b1, 1'b0, 16'h1111, 2'b11, 2'b11, 1'b0, 1'b0);
    idle(1'b0);
    check("t2_pulse",  32'(err_pulse),  32'h01);
    check("t2_sticky", 32'(err_sticky), 32'h01);
    check("t2_first",  32'(first_err),  32'h01);

    // T3: payload change during stall, then a held payload.
    idle(1'b1);
    cycle(1'b1, 1'b0, 16'h00A5, 2'b11, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h005A, 2'b11, 2'b11, 1'b0, 1'b0);
    check("t3_change", 32'(err_pulse), 32'h02);
    cycle(1'b1, 1'b1, 16'h005A, 2'b11, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h00A5, 2'b11, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h00A5, 2'b11, 2'b11, 1'b0, 1'b0);
    check("t3_held", 32'(err_pulse), 32'h00);
    cycle(1'b1, 1'b1, 16'h00A5, 2'b11, 2'b11, 1'b1, 1'b0);

    // T4: ten stall cycles raise exactly one timeout.
    idle(1'b1);
    n_timeout = 0;
    repeat (10) cycle(1'b1, 1'b0, 16'h0042, 2'b11, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0042, 2'b11, 2'b11, 1'b1, 1'b0);
    check("t4_timeouts", 32'(n_timeout), 32'd1);

    // T5: five-beat packet against a three-beat limit.
    idle(1'b1);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b1, DW'(i), 2'b11, 2'b11, i == 5, 1'b0);
      if (i == 4) check("t5_too_long", 32'(err_pulse), 32'h10);
    end
    check("t5_beats", 32'(beat_count), 32'd5);
    check("t5_pkts",  32'(pkt_count),  32'd1);

    // T6: strobe outside keep in the same cycle as clr.
    cycle(1'b1, 1'b0, 16'h0077, 2'b01, 2'b11, 1'b1, 1'b1);
    check("t6_sticky", 32'(err_sticky), 32'h04);
    check("t6_first",  32'(first_err),  32'h04);
    check("t6_beats",  32'(beat_count), 32'd0);
    cycle(1'b1, 1'b1, 16'h0077, 2'b01, 2'b11, 1'b1, 1'b0);

    // Sparse keep on a non-last beat, then two simultaneous violations.
    idle(1'b1);
    cycle(1'b1, 1'b1, 16'h0010, 2'b01, 2'b01, 1'b0, 1'b0);
    check("sparse_keep", 32'(err_pulse), 32'h20);
    cycle(1'b1, 1'b1, 16'h0011, 2'b11, 2'b11, 1'b1, 1'b0);
    idle(1'b1);
    cycle(1'b1, 1'b0, 16'h0020, 2'b01, 2'b11, 1'b0, 1'b0);
    idle(1'b0);
    check("multi_first",  32'(first_err),  32'h24);
    check("multi_sticky", 32'(err_sticky), 32'h25);

    // Counter saturation.
    idle(1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1, DW'(i), 2'b11, 2'b11, 1'b1, 1'b0);
    check("sat_beats", 32'(beat_count), 32'(CNT_SAT));
    check("sat_pkts",  32'(pkt_count),  32'(CNT_SAT));

    // Random traffic against the model.
    idle(1'b1);
    for (int i = 0; i < 60; i++) begin
      logic [KW-1:0] rk, rs;
      rk = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b11;
      rs = ($urandom_range(0, 4) == 0) ? 2'b11 : rk;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            DW'($urandom_range(0, 3)), rk, rs,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
